// File: rtl/axis_400g_tx_pkt_fifo.sv
// Store-and-forward packet FIFO for the 400G TX path. A packet is released to the
// DCMAC adapter only once fully stored. Bad or overflowing packets are discarded.
module axis_400g_tx_pkt_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1023:0]            s_tdata,
  input  logic [127:0]             s_tkeep,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic                     s_tuser,
  output logic [1023:0]            m_tdata,
  output logic [127:0]             m_tkeep,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [CNT_W-1:0]         drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 1024 + 128 + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_commit_ptr, r_commit_rd, r_rd_ptr;
  logic            r_ready, r_commit_d, r_m_valid;
  logic [DW-1:0]   r_m_beat;
  logic [PW-1:0]   r_pkt_count;
  logic [CNT_W-1:0] r_drop_count;
  logic            w_accept, w_full, w_have, w_load, w_pkt_out;
  logic            w_wr_en, w_commit, w_rollback, w_drop;

  assign w_accept = s_tvalid && r_ready;
  // The read side only sees commits one cycle late, which also gives a 2-edge release latency.
  assign w_have   = (r_rd_ptr != r_commit_rd);
  assign w_load   = w_have && (!r_m_valid || m_tready);
  // A slot popped this cycle can be refilled on the same edge (read-before-write).
  assign w_full   = ((r_wr_ptr - r_rd_ptr) == PW'(DEPTH)) && !w_load;
  assign w_pkt_out = r_m_valid && m_tready && r_m_beat[DW-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_drop      = 1'b0;
    if (w_accept) begin
      if (r_state == S_DROP) begin
        if (s_tlast) w_state_nxt = S_IDLE;
      end else if (w_full) begin
        w_rollback  = 1'b1;
        w_drop      = 1'b1;
        w_state_nxt = s_tlast ? S_IDLE : S_DROP;
      end else if (s_tlast && s_tuser) begin
        w_rollback  = 1'b1;
        w_drop      = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_wr_en     = 1'b1;
        w_commit    = s_tlast;
        w_state_nxt = s_tlast ? S_IDLE : S_WRITE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_commit_rd  <= '0;
      r_commit_d   <= 1'b0;
      r_rd_ptr     <= '0;
      r_m_valid    <= 1'b0;
      r_m_beat     <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= 1'b1;
      r_commit_rd <= r_commit_ptr;
      r_commit_d  <= w_commit;
      if (w_rollback)    r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_commit)      r_commit_ptr <= r_wr_ptr + 1'b1;
      if (w_drop)        r_drop_count <= r_drop_count + 1'b1;
      if (w_load) begin
        r_m_beat  <= r_mem[r_rd_ptr[AW-1:0]];
        r_m_valid <= 1'b1;
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end else if (m_tready) begin
        r_m_valid <= 1'b0;
      end
      case ({r_commit_d, w_pkt_out})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
  end

  assign s_tready   = r_ready;
  assign m_tvalid   = r_m_valid;
  assign m_tdata    = r_m_beat[1023:0];
  assign m_tkeep    = r_m_beat[1151:1024];
  assign m_tlast    = r_m_beat[DW-1];
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_axis_400g_tx_pkt_fifo.sv
// Directed bench for axis_400g_tx_pkt_fifo (DEPTH=8): latency, ordering, stalls,
// bad/overflow drops, one-packet-per-cycle streaming and mid-packet reset.
module tb_axis_400g_tx_pkt_fifo;
  localparam int DEPTH = 8;

  typedef struct {
    logic [1023:0] data;
    logic [127:0]  keep;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [1023:0]  s_tdata;
  logic [127:0]   s_tkeep;
  logic           s_tvalid, s_tready, s_tlast, s_tuser;
  logic [1023:0]  m_tdata;
  logic [127:0]   m_tkeep;
  logic           m_tvalid, m_tready, m_tlast;
  logic [3:0]     pkt_count;
  logic [31:0]    drop_count;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  bit    tog = 0;
  bit    phase5 = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    first_hs = -1;
  int    last_hs = 0;
  bit    in_pkt = 0;
  bit    stalled = 0;
  logic [1023:0] prev_data;
  logic [127:0]  prev_keep;
  logic          prev_last;

  axis_400g_tx_pkt_fifo #(.DEPTH(DEPTH), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] mk_data(input int id, input int b);
    return {64{8'(id), 8'(b)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) m_tready = ~m_tready;
  endtask

  task automatic send_pkt(input int id, input int n, input logic [127:0] last_keep,
                          input logic user, input bit exp_ok);
    beat_t bt;
    if (exp_ok)
      for (int b = 0; b < n; b++) begin
        bt.data = mk_data(id, b);
        bt.keep = (b == n - 1) ? last_keep : '1;
        bt.last = (b == n - 1);
        exp_q.push_back(bt);
      end
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = mk_data(id, b);
      s_tkeep  = (b == n - 1) ? last_keep : '1;
      s_tlast  = (b == n - 1);
      s_tuser  = (b == n - 1) ? user : 1'b0;
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check({tag, "_left"}, exp_q.size(), 0);
    step();
    step();
  endtask

  // Output monitor: scoreboard, stall stability and in-packet continuity.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!rst) begin
      in_pkt  = 0;
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_keep", m_tkeep, prev_keep);
        check("stall_last", m_tlast, prev_last);
        for (int i = 0; i < 8; i++)
          check($sformatf("stall_data%0d", i), m_tdata[i*128 +: 128], prev_data[i*128 +: 128]);
      end
      if (in_pkt) check("no_gap", m_tvalid, 1);
      if (phase5) check("pkt_le2", pkt_count <= 4'd2, 1);
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        if (phase5 && first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        in_pkt  = !m_tlast;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", hs_cnt, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_keep", m_tkeep, e.keep);
          check("out_last", m_tlast, e.last);
          for (int i = 0; i < 8; i++)
            check($sformatf("out_data%0d", i), m_tdata[i*128 +: 128], e.data[i*128 +: 128]);
        end
      end
      stalled   = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_keep = m_tkeep;
      prev_last = m_tlast;
    end
  end

  initial begin
    int base;
    rst = 1'b0; m_tready = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    #2;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tdata_lo", m_tdata[127:0], 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    step(); step();
    rst = 1'b1;
    #1;
    check("ready_before_edge", s_tready, 0);
    step();
    check("ready_after_edge", s_tready, 1);

    // 1: single 4-beat packet, latency and short last keep
    m_tready = 1'b1;
    send_pkt(1, 4, 128'hFF, 1'b0, 1);
    step();
    check("t1_valid_k1", m_tvalid, 0);
    step();
    check("t1_valid_k2", m_tvalid, 1);
    check("t1_pkt_count", pkt_count, 1);
    drain("t1", 30);
    check("t1_pkt_count_end", pkt_count, 0);

    // 2: three back-to-back 3-beat packets with m_tready toggling
    tog = 1;
    send_pkt(2, 3, '1, 1'b0, 1);
    send_pkt(3, 3, '1, 1'b0, 1);
    send_pkt(4, 3, 128'h0FFF, 1'b0, 1);
    drain("t2", 60);
    tog = 0;
    m_tready = 1'b1;
    step();
    check("t2_pkt_count", pkt_count, 0);

    // 3: bad packet discarded, following good one intact
    send_pkt(5, 3, '1, 1'b1, 0);
    step(); step(); step();
    check("t3_valid", m_tvalid, 0);
    check("t3_drop_count", drop_count, 1);
    check("t3_pkt_count", pkt_count, 0);
    send_pkt(6, 2, 128'h3, 1'b0, 1);
    drain("t3", 30);

    // 4: overflow of an 8-deep buffer with egress stalled
    m_tready = 1'b0;
    send_pkt(7, 10, '1, 1'b0, 0);
    check("t4_drop_count", drop_count, 2);
    check("t4_pkt_count_drop", pkt_count, 0);
    send_pkt(8, 2, 128'hF, 1'b0, 1);
    step(); step(); step();
    check("t4_pkt_count", pkt_count, 1);
    check("t4_valid_held", m_tvalid, 1);
    m_tready = 1'b1;
    drain("t4", 30);
    check("t4_pkt_count_end", pkt_count, 0);

    // 5: one single-beat packet per cycle
    phase5 = 1;
    for (int p = 0; p < 12; p++) send_pkt(50 + p, 1, '1, 1'b0, 1);
    drain("t5", 30);
    phase5 = 0;
    check("t5_throughput", last_hs - first_hs, 11);
    check("t5_no_drop", drop_count, 2);

    // 6: reset while a 5-beat packet is halfway out
    send_pkt(9, 5, '1, 1'b0, 1);
    base = hs_cnt;
    for (int i = 0; i < 40 && hs_cnt < base + 2; i++) step();
    check("t6_beats_before_rst", hs_cnt - base, 2);
    check("t6_valid_before_rst", m_tvalid, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_valid_rst", m_tvalid, 0);
    check("t6_pkt_count_rst", pkt_count, 0);
    check("t6_drop_count_rst", drop_count, 0);
    check("t6_ready_rst", s_tready, 0);
    exp_q.delete();
    step(); step();
    rst = 1'b1;
    step();
    check("t6_ready_release", s_tready, 1);
    step(); step();
    check("t6_no_partial", m_tvalid, 0);
    send_pkt(10, 3, 128'h1, 1'b0, 1);
    drain("t6", 30);
    check("t6_pkt_count_end", pkt_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
